// File: rtl/f32_to_i32_if.sv
// Handshake bundle for the FP32 -> INT32 converter: operand in, result plus flags out.
interface f32_to_i32_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_flags;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/f32_to_i32_seq.sv
// Iterative FP32 -> signed INT32 converter with a SHIFT_STEP-bit-per-cycle shifter.
// Truncates toward zero by default; `define F32_TO_I32_ROUND_NEAREST_EN for round-to-nearest-even.
module f32_to_i32_seq #(
  parameter int SHIFT_STEP = 1
) (
  input logic          clk,
  input logic          rst,
  f32_to_i32_seq_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

`ifdef F32_TO_I32_ROUND_NEAREST_EN
  // |x| in [0.5,1) must reach the rounder, so the fast zero path starts one exponent lower
  localparam logic [7:0] MIN_EXP = 8'd126;
`else
  localparam logic [7:0] MIN_EXP = 8'd127;
`endif

  generate
    if (!(SHIFT_STEP == 1 || SHIFT_STEP == 2 || SHIFT_STEP == 4 || SHIFT_STEP == 8)) begin : g_bad_step
      $error("f32_to_i32_seq: SHIFT_STEP must be 1, 2, 4 or 8");
    end
  endgenerate

  logic [1:0]  state;
  logic [31:0] mag;
  logic [4:0]  cnt;
  logic        dir_left;
  logic        sign;
  logic        inexact;
  logic [31:0] data_q;
  logic [2:0]  flags_q;

  // operand decode
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [22:0] in_mant;
  logic        is_nan, is_int_min, is_big, is_zero, is_tiny, go_left;
  logic [4:0]  left_cnt, right_cnt;

  always_comb begin
    in_sign    = bus.in_data[31];
    in_exp     = bus.in_data[30:23];
    in_mant    = bus.in_data[22:0];
    is_nan     = (in_exp == 8'hFF) && (in_mant != 23'd0);
    is_int_min = (bus.in_data == 32'hCF00_0000);
    is_big     = (in_exp >= 8'd158);
    is_zero    = (in_exp == 8'd0);
    is_tiny    = (in_exp < MIN_EXP);
    go_left    = (in_exp >= 8'd150);
    // 150 = 127 + 23 and 150 mod 32 = 22; the true distance always fits in 5 bits
    left_cnt   = in_exp[4:0] - 5'd22;
    right_cnt  = 5'd22 - in_exp[4:0];
  end

  // one shifter step
  logic [4:0]  step;
  logic [31:0] lost_mask;
  logic        lost_any;

  always_comb begin
    step      = (cnt < STEP) ? cnt : STEP;
    lost_mask = (32'd1 << step) - 32'd1;
    lost_any  = !dir_left && ((mag & lost_mask) != 32'd0);
  end

  logic [31:0] mag_fin;
  logic [31:0] result;

`ifdef F32_TO_I32_ROUND_NEAREST_EN
  logic        rnd, sticky;
  logic [31:0] last_mask;
  logic        last_bit, early_any;

  always_comb begin
    last_mask = 32'd1 << (step - 5'd1);
    last_bit  = (mag & last_mask) != 32'd0;
    early_any = (mag & (last_mask - 32'd1)) != 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rnd    <= 1'b0;
      sticky <= 1'b0;
    end else if (state == S_IDLE && bus.in_valid) begin
      rnd    <= 1'b0;
      sticky <= 1'b0;
    end else if (state == S_SHIFT && cnt != 5'd0 && !dir_left) begin
      // everything that left before this step's last bit feeds sticky
      sticky <= sticky | rnd | early_any;
      rnd    <= last_bit;
    end
  end

  assign mag_fin = mag + {31'd0, rnd & (sticky | mag[0])};
`else
  assign mag_fin = mag;
`endif

  assign result = sign ? (~mag_fin + 32'd1) : mag_fin;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mag      <= 32'd0;
      cnt      <= 5'd0;
      dir_left <= 1'b0;
      sign     <= 1'b0;
      inexact  <= 1'b0;
      data_q   <= 32'd0;
      flags_q  <= 3'b000;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            inexact <= 1'b0;
            flags_q <= 3'b000;
            if (is_nan) begin
              data_q  <= 32'd0;
              flags_q <= 3'b100;
              state   <= S_DONE;
            end else if (is_int_min) begin
              data_q <= 32'h8000_0000;
              state  <= S_DONE;
            end else if (is_big) begin
              // covers infinities as well as finite values beyond the int32 range
              data_q  <= in_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
              flags_q <= 3'b010;
              state   <= S_DONE;
            end else if (is_zero) begin
              data_q  <= 32'd0;
              flags_q <= {2'b00, in_mant != 23'd0};
              state   <= S_DONE;
            end else if (is_tiny) begin
              data_q  <= 32'd0;
              flags_q <= 3'b001;
              state   <= S_DONE;
            end else begin
              mag      <= {8'd0, 1'b1, in_mant};
              dir_left <= go_left;
              cnt      <= go_left ? left_cnt : right_cnt;
              sign     <= in_sign;
              state    <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          if (cnt == 5'd0) begin
            state <= S_FINISH;
          end else begin
            mag     <= dir_left ? (mag << step) : (mag >> step);
            cnt     <= cnt - step;
            inexact <= inexact | lost_any;
          end
        end
        S_FINISH: begin
          data_q  <= result;
          flags_q <= {2'b00, inexact};
          state   <= S_DONE;
        end
        default: begin
          if (bus.out_ready) state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.out_data  = data_q;
  assign bus.out_flags = flags_q;
endmodule
